// File: rtl/aes_block_gearbox_if.sv
// Control, stream and cipher-core signals of the AES block gearbox.
// slave = gearbox side, master = environment (source, sink, core, controller).
interface aes_block_gearbox_if #(
   parameter int DATA_WIDTH  = 32,
   parameter int BLOCK_WIDTH = 128,
   parameter int CNT_WIDTH   = 16
);
   logic                      clear_i;
   logic                      start_i;
   logic [CNT_WIDTH-1:0]      n_blocks_i;
   logic                      bypass_i;
   logic [DATA_WIDTH-1:0]     in_data_i;
   logic                      in_valid_i;
   logic                      in_ready_o;
   logic [DATA_WIDTH-1:0]     out_data_o;
   logic                      out_valid_o;
   logic                      out_ready_i;
   logic [DATA_WIDTH/8-1:0]   out_strb_o;
   logic                      core_req_o;
   logic [BLOCK_WIDTH-1:0]    core_data_o;
   logic                      core_gnt_i;
   logic                      core_rvalid_i;
   logic [BLOCK_WIDTH-1:0]    core_rdata_i;
   logic                      busy_o;
   logic                      done_o;
   logic [CNT_WIDTH-1:0]      blk_cnt_o;

   modport slave (
      input  clear_i, start_i, n_blocks_i, bypass_i, in_data_i, in_valid_i, out_ready_i,
             core_gnt_i, core_rvalid_i, core_rdata_i,
      output in_ready_o, out_data_o, out_valid_o, out_strb_o, core_req_o, core_data_o,
             busy_o, done_o, blk_cnt_o
   );

   modport master (
      output clear_i, start_i, n_blocks_i, bypass_i, in_data_i, in_valid_i, out_ready_i,
             core_gnt_i, core_rvalid_i, core_rdata_i,
      input  in_ready_o, out_data_o, out_valid_o, out_strb_o, core_req_o, core_data_o,
             busy_o, done_o, blk_cnt_o
   );
endinterface

// File: rtl/aes_block_gearbox.sv
// Packs WORDS stream words into a block, runs it through the cipher core (or bypass), unpacks it again.
// Output valid 1 cycle after last input word (bypass) or core rvalid; input stalls outside FILL, output waits on out_ready_i.
module aes_block_gearbox #(
   parameter int DATA_WIDTH  = 32,
   parameter int BLOCK_WIDTH = 128,
   parameter int CNT_WIDTH   = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   aes_block_gearbox_if.slave bus
);
   localparam int WORDS = BLOCK_WIDTH / DATA_WIDTH;
   localparam int WW    = (WORDS > 1) ? $clog2(WORDS) : 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FILL  = 3'd1;
   localparam logic [2:0] S_REQ   = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_DRAIN = 3'd4;

   if ((BLOCK_WIDTH % DATA_WIDTH) != 0) begin : g_width_check
      $error("BLOCK_WIDTH must be an integer multiple of DATA_WIDTH");
   end

   logic [2:0]             r_state;
   logic [BLOCK_WIDTH-1:0] r_block;
   logic [WW-1:0]          r_word;
   logic [CNT_WIDTH-1:0]   r_blk_cnt;
   logic [CNT_WIDTH-1:0]   r_n_blocks;
   logic                   r_bypass;
   logic                   r_done;

   logic                   w_last_word;
   logic [CNT_WIDTH-1:0]   w_blk_nxt;
   int                     w_ofs;

   assign w_last_word = (r_word == WW'(WORDS - 1));
   assign w_blk_nxt   = r_blk_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   assign w_ofs       = int'(r_word) * DATA_WIDTH;

   always_ff @(posedge clk_i) begin
      if (rst_i || bus.clear_i) begin
         r_state    <= S_IDLE;
         r_block    <= '0;
         r_word     <= '0;
         r_blk_cnt  <= '0;
         r_n_blocks <= '0;
         r_bypass   <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start_i) begin
                  if (bus.n_blocks_i != '0) begin
                     r_n_blocks <= bus.n_blocks_i;
                     r_bypass   <= bus.bypass_i;
                     r_blk_cnt  <= '0;
                     r_state    <= S_FILL;
                  end else begin
                     r_done <= 1'b1;
                  end
               end
            end
            S_FILL: begin
               if (bus.in_valid_i) begin
                  r_block[w_ofs +: DATA_WIDTH] <= bus.in_data_i;
                  if (w_last_word) begin
                     r_word  <= '0;
                     r_state <= r_bypass ? S_DRAIN : S_REQ;
                  end else begin
                     r_word <= r_word + 1'b1;
                  end
               end
            end
            S_REQ: begin
               // A result arriving together with the grant is taken immediately.
               if (bus.core_gnt_i) begin
                  if (bus.core_rvalid_i) begin
                     r_block <= bus.core_rdata_i;
                     r_state <= S_DRAIN;
                  end else begin
                     r_state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (bus.core_rvalid_i) begin
                  r_block <= bus.core_rdata_i;
                  r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (bus.out_ready_i) begin
                  if (w_last_word) begin
                     r_word    <= '0;
                     r_blk_cnt <= w_blk_nxt;
                     if (w_blk_nxt == r_n_blocks) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                     end else begin
                        r_state <= S_FILL;
                     end
                  end else begin
                     r_word <= r_word + 1'b1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready_o  = (r_state == S_FILL);
   assign bus.out_valid_o = (r_state == S_DRAIN);
   assign bus.out_data_o  = r_block[w_ofs +: DATA_WIDTH];
   assign bus.out_strb_o  = '1;
   assign bus.core_req_o  = (r_state == S_REQ);
   assign bus.core_data_o = r_block;
   assign bus.busy_o      = (r_state != S_IDLE);
   assign bus.done_o      = r_done;
   assign bus.blk_cnt_o   = r_blk_cnt;
endmodule
